// File: rtl/pcie_datalink_crc_stream.sv
// rtl/pcie_datalink_crc_stream.sv - streaming byte-lane CRC engine for PCIe DLLP CRC16 / TLP LCRC32
module pcie_datalink_crc_stream #(
    parameter int                   DATA_WIDTH      = 32,
    parameter int                   KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int                   CRC_WIDTH       = 16,
    parameter logic [CRC_WIDTH-1:0] POLY            = 16'h100B,
    parameter logic [CRC_WIDTH-1:0] INIT            = '1,
    parameter bit                   OUT_INVERT      = 1'b1,
    parameter bit                   OUT_BIT_REVERSE = 1'b1,
    parameter int                   COUNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [CRC_WIDTH-1:0]   m_crc,
    output logic [COUNT_WIDTH-1:0] m_crc_bytes,
    output logic                   m_crc_valid,
    input  logic                   m_crc_ready
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CRC_WIDTH-1:0]   crc_q, crc_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CRC_WIDTH-1:0]   res_q, res_d;
    logic [COUNT_WIDTH-1:0] bytes_q, bytes_d;
    logic                   accept;
    logic [CRC_WIDTH-1:0]   crc_next;
    logic [COUNT_WIDTH-1:0] cnt_next;

    // Fold every enabled lane, lowest lane first, MSB of each byte first.
    function automatic logic [CRC_WIDTH-1:0] fold(input logic [CRC_WIDTH-1:0]  c_in,
                                                  input logic [DATA_WIDTH-1:0] d,
                                                  input logic [KEEP_WIDTH-1:0] k);
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c = c_in;
        for (int l = 0; l < KEEP_WIDTH; l++) begin
            if (k[l]) begin
                for (int b = 7; b >= 0; b--) begin
                    fb = c[CRC_WIDTH-1] ^ d[8*l+b];
                    c  = {c[CRC_WIDTH-2:0], 1'b0};
                    if (fb) c = c ^ POLY;
                end
            end
        end
        return c;
    endfunction

    // Byte count plus popcount of the enables, clamped at all ones.
    function automatic logic [COUNT_WIDTH-1:0] count_add(input logic [COUNT_WIDTH-1:0] c_in,
                                                         input logic [KEEP_WIDTH-1:0]  k);
        logic [COUNT_WIDTH:0] sum;
        sum = {1'b0, c_in};
        for (int l = 0; l < KEEP_WIDTH; l++) begin
            sum = sum + (COUNT_WIDTH+1)'(k[l]);
        end
        return sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
    endfunction

    // Output transform: complement first, then mirror bits inside each byte.
    function automatic logic [CRC_WIDTH-1:0] transform(input logic [CRC_WIDTH-1:0] c_in);
        logic [CRC_WIDTH-1:0] r;
        logic [CRC_WIDTH-1:0] t;
        r = OUT_INVERT ? ~c_in : c_in;
        t = r;
        if (OUT_BIT_REVERSE) begin
            for (int k = 0; k < CRC_WIDTH / 8; k++) begin
                for (int i = 0; i < 8; i++) begin
                    t[8*k+i] = r[8*k+7-i];
                end
            end
        end
        return t;
    endfunction

    assign m_crc_valid   = (state_q == DONE);
    assign s_axis_tready = !m_crc_valid || m_crc_ready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign crc_next      = fold(crc_q, s_axis_tdata, s_axis_tkeep);
    assign cnt_next      = count_add(cnt_q, s_axis_tkeep);
    assign m_crc         = res_q;
    assign m_crc_bytes   = bytes_q;

    // Next state: a consumed result frees the output; an accepted beat may start the next frame in the same cycle.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        bytes_d = bytes_q;
        if (state_q == DONE && m_crc_ready) begin
            state_d = IDLE;
        end
        if (accept) begin
            if (s_axis_tlast) begin
                res_d   = transform(crc_next);
                bytes_d = cnt_next;
                crc_d   = INIT;
                cnt_d   = '0;
                state_d = DONE;
            end else begin
                crc_d   = crc_next;
                cnt_d   = cnt_next;
                state_d = ACTIVE;
            end
        end
    end

    // State, running CRC/count and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            cnt_q   <= '0;
            res_q   <= '0;
            bytes_q <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            bytes_q <= bytes_d;
        end
    end

endmodule

// File: tb/tb_pcie_datalink_crc_stream.sv
// tb/tb_pcie_datalink_crc_stream.sv - self-checking bench for pcie_datalink_crc_stream
module tb_pcie_datalink_crc_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Instance A: CRC16/CCITT-FALSE on a 32-bit bus, with a reference model.
    logic        rst = 1'b1;
    logic [31:0] a_tdata = '0;
    logic [3:0]  a_tkeep = '0;
    logic        a_tvalid = 1'b0, a_tlast = 1'b0, a_ready = 1'b1;
    logic        a_tready, a_valid;
    logic [15:0] a_crc, a_bytes;

    pcie_datalink_crc_stream #(.DATA_WIDTH(32), .CRC_WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF),
                               .OUT_INVERT(1'b0), .OUT_BIT_REVERSE(1'b0)) u_a (
        .clk(clk), .rst(rst), .s_axis_tdata(a_tdata), .s_axis_tkeep(a_tkeep),
        .s_axis_tvalid(a_tvalid), .s_axis_tlast(a_tlast), .s_axis_tready(a_tready),
        .m_crc(a_crc), .m_crc_bytes(a_bytes), .m_crc_valid(a_valid), .m_crc_ready(a_ready));

    // Instances B/C: LCRC32 on a 64-bit bus, without and with output inversion.
    logic [63:0] b_tdata = '0;
    logic [7:0]  b_tkeep = '0;
    logic        b_tvalid = 1'b0, b_tlast = 1'b0;
    logic        b_tready, c_tready, b_valid, c_valid;
    logic [31:0] b_crc, c_crc;
    logic [15:0] b_bytes, c_bytes;

    pcie_datalink_crc_stream #(.DATA_WIDTH(64), .CRC_WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                               .OUT_INVERT(1'b0), .OUT_BIT_REVERSE(1'b0)) u_b (
        .clk(clk), .rst(rst), .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep),
        .s_axis_tvalid(b_tvalid), .s_axis_tlast(b_tlast), .s_axis_tready(b_tready),
        .m_crc(b_crc), .m_crc_bytes(b_bytes), .m_crc_valid(b_valid), .m_crc_ready(1'b1));

    pcie_datalink_crc_stream #(.DATA_WIDTH(64), .CRC_WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                               .OUT_INVERT(1'b1), .OUT_BIT_REVERSE(1'b0)) u_c (
        .clk(clk), .rst(rst), .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep),
        .s_axis_tvalid(b_tvalid), .s_axis_tlast(b_tlast), .s_axis_tready(c_tready),
        .m_crc(c_crc), .m_crc_bytes(c_bytes), .m_crc_valid(c_valid), .m_crc_ready(1'b1));

    // Instance D: default parameters.
    logic [31:0] d_tdata = 32'hDEADBEEF;
    logic [3:0]  d_tkeep = '0;
    logic        d_tvalid = 1'b0, d_tlast = 1'b0;
    logic        d_tready, d_valid;
    logic [15:0] d_crc, d_bytes;

    pcie_datalink_crc_stream u_d (
        .clk(clk), .rst(rst), .s_axis_tdata(d_tdata), .s_axis_tkeep(d_tkeep),
        .s_axis_tvalid(d_tvalid), .s_axis_tlast(d_tlast), .s_axis_tready(d_tready),
        .m_crc(d_crc), .m_crc_bytes(d_bytes), .m_crc_valid(d_valid), .m_crc_ready(1'b1));

    // Bit-serial reference CRC over a byte list, MSB first, no output transform.
    function automatic logic [15:0] ref_crc16(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[j]) begin
            for (int i = 7; i >= 0; i--) begin
                if (c[15] ^ q[j][i]) c = (c << 1) ^ 16'h1021;
                else                 c = c << 1;
            end
        end
        return c;
    endfunction

    // Model of instance A: byte list of the open frame and the pending result.
    logic [7:0]  frame[$];
    logic        exp_valid = 1'b0;
    logic [15:0] exp_crc = '0, exp_bytes = '0;
    logic        model_on = 1'b0;

    initial forever begin
        logic acc;
        @(posedge clk);
        if (rst) begin
            exp_valid = 1'b0;
            frame.delete();
        end else begin
            acc = a_tvalid && (!exp_valid || a_ready);
            if (exp_valid && a_ready) exp_valid = 1'b0;
            if (acc) begin
                for (int l = 0; l < 4; l++) if (a_tkeep[l]) frame.push_back(a_tdata[8*l +: 8]);
                if (a_tlast) begin
                    exp_crc   = ref_crc16(frame);
                    exp_bytes = 16'(frame.size());
                    exp_valid = 1'b1;
                    frame.delete();
                end
            end
        end
    end

    // Per-cycle compare of instance A against the model.
    initial forever begin
        @(negedge clk);
        if (model_on && !rst) begin
            check("a_valid", 64'(a_valid), 64'(exp_valid));
            check("a_tready", 64'(a_tready), 64'(!exp_valid || a_ready));
            if (exp_valid) begin
                check("a_crc", 64'(a_crc), 64'(exp_crc));
                check("a_bytes", 64'(a_bytes), 64'(exp_bytes));
            end
        end
    end

    int last_wait;

    task automatic send_a(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic acc;
        a_tdata = d; a_tkeep = k; a_tlast = l; a_tvalid = 1'b1;
        last_wait = 0;
        do begin
            @(negedge clk);
            acc = a_tready;
            @(posedge clk); #1;
            last_wait++;
        end while (!acc && last_wait < 50);
        if (!acc) check("a_send_timeout", 64'(acc), 64'd1);
        a_tvalid = 1'b0; a_tlast = 1'b0;
    endtask

    task automatic send_b(input logic [63:0] d, input logic [7:0] k, input logic l);
        b_tdata = d; b_tkeep = k; b_tlast = l; b_tvalid = 1'b1;
        @(posedge clk); #1;
        b_tvalid = 1'b0; b_tlast = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Hand-computed result check for instance A, sampled the cycle after tlast.
    task automatic pin_a(input string name, input logic [15:0] crc, input logic [15:0] n);
        @(negedge clk);
        check({name, "_valid"}, 64'(a_valid), 64'd1);
        check({name, "_crc"}, 64'(a_crc), 64'(crc));
        check({name, "_bytes"}, 64'(a_bytes), 64'(n));
    endtask

    initial begin
        logic [15:0] held_crc, held_bytes;
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tready", 64'(a_tready), 64'd1);
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_crc", 64'(a_crc), 64'd0);
        check("rst_bytes", 64'(a_bytes), 64'd0);
        @(posedge clk); #1;
        model_on = 1'b1;

        // Test 1: "123456789" as 4+4+1 bytes.
        send_a(32'h34333231, 4'hF, 1'b0);
        send_a(32'h38373635, 4'hF, 1'b0);
        send_a(32'h00000039, 4'h1, 1'b1);
        pin_a("t1", 16'h29B1, 16'd9);
        cycles(2);

        // Test 4: non-contiguous keep drops 'x'; also a non-last empty beat.
        send_a(32'h33783231, 4'b1011, 1'b0);
        send_a(32'h37363534, 4'hF, 1'b0);
        send_a(32'hAAAAAAAA, 4'h0, 1'b0);
        send_a(32'h00000038, 4'h1, 1'b0);
        send_a(32'h00000039, 4'h1, 1'b1);
        pin_a("t4", 16'h29B1, 16'd9);
        cycles(2);

        // Test 5: result held under back-pressure, zero-bubble restart.
        a_ready = 1'b0;
        send_a(32'h34333231, 4'hF, 1'b0);
        send_a(32'h38373635, 4'hF, 1'b0);
        send_a(32'h00000039, 4'h1, 1'b1);
        @(negedge clk);
        held_crc = a_crc; held_bytes = a_bytes;
        check("t5_first", 64'(held_crc), 64'h29B1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_stall_tready", 64'(a_tready), 64'd0);
            check("t5_hold_crc", 64'(a_crc), 64'(held_crc));
            check("t5_hold_bytes", 64'(a_bytes), 64'(held_bytes));
        end
        @(posedge clk); #1;
        a_ready = 1'b1;
        send_a(32'h00000041, 4'h1, 1'b1);
        check("t5_zero_bubble", 64'(last_wait), 64'd1);
        pin_a("t5_f2", 16'hB915, 16'd1);
        cycles(2);

        // Test 6: reset mid-frame, then a clean frame.
        send_a(32'h34333231, 4'hF, 1'b0);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", 64'(a_valid), 64'd0);
        @(posedge clk); #1;
        send_a(32'h34333231, 4'hF, 1'b0);
        send_a(32'h38373635, 4'hF, 1'b0);
        send_a(32'h00000039, 4'h1, 1'b1);
        pin_a("t6", 16'h29B1, 16'd9);
        cycles(2);

        // Test 2: LCRC32 on 64-bit bus, 8+1 bytes.
        send_b(64'h3837363534333231, 8'hFF, 1'b0);
        check("t2_no_early", 64'(b_valid), 64'd0);
        send_b(64'h0000000000000039, 8'h01, 1'b1);
        @(negedge clk);
        check("t2_valid", 64'(b_valid), 64'd1);
        check("t2_crc_noinv", 64'(b_crc), 64'h0376E6E7);
        check("t2_crc_inv", 64'(c_crc), 64'hFC891918);
        check("t2_bytes", 64'(b_bytes), 64'd9);
        check("t2_bytes_c", 64'(c_bytes), 64'd9);
        cycles(2);

        // Test 3: defaults, empty frame.
        d_tkeep = 4'h0; d_tlast = 1'b1; d_tvalid = 1'b1;
        @(posedge clk); #1;
        d_tvalid = 1'b0; d_tlast = 1'b0;
        @(negedge clk);
        check("t3_valid", 64'(d_valid), 64'd1);
        check("t3_crc", 64'(d_crc), 64'h0000);
        check("t3_bytes", 64'(d_bytes), 64'd0);
        check("t3_tready", 64'(d_tready), 64'd1);
        cycles(2);

        model_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pcie_datalink_crc_stream.md
Name: pcie_datalink_crc_stream

Overview:
Streaming, parametrised CRC engine for the PCIe data link layer. It consumes an AXI-Stream frame of any length and width, folds in only the byte lanes that are enabled, and returns one CRC result per frame through a valid/ready output. The same block covers the DLLP CRC16 and the TLP LCRC32 through parameters. It sits between the DLL framing logic and the TX/RX CRC insert/check stages.

Parameters:
DATA_WIDTH, 32, input bus width in bits; multiple of 8, range 8..256.
KEEP_WIDTH, DATA_WIDTH/8, number of byte-enable lanes.
CRC_WIDTH, 16, CRC width; either 16 or 32.
POLY, 16'h100B, generator polynomial with the implicit top bit dropped; 32'h04C11DB7 for LCRC.
INIT, all ones, CRC register value at the start of each frame.
OUT_INVERT, 1, when 1 the result is bitwise complemented.
OUT_BIT_REVERSE, 1, when 1 the bit order is reversed within each result byte (bit i of byte k goes to bit 7-i of byte k).
COUNT_WIDTH, 16, width of the frame byte counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  DATA_WIDTH  frame data; lane 0 (bits [7:0]) is the earliest byte.
s_axis_tkeep  in  KEEP_WIDTH  byte enables.
s_axis_tvalid  in  1  input beat valid.
s_axis_tlast  in  1  marks the final beat of a frame.
s_axis_tready  out  1  input beat accepted when high.
m_crc  out  CRC_WIDTH  final CRC of the frame, after the output transform.
m_crc_bytes  out  COUNT_WIDTH  number of enabled bytes in the frame; saturates at all ones.
m_crc_valid  out  1  result valid.
m_crc_ready  in  1  result consumed when high.

Behaviour:
- Reset values:
  - s_axis_tready=1, m_crc_valid=0, m_crc=0, m_crc_bytes=0.
  - Internal CRC register = INIT, byte count = 0, state = IDLE.
- Beat acceptance: a beat is accepted when s_axis_tvalid && s_axis_tready.
- Per accepted beat:
  - Each lane with tkeep=1 is folded in ascending lane order. Lanes with tkeep=0 are skipped; tkeep does not have to be contiguous.
  - Within a byte, bit 7 enters first. The shift is MSB-first and non-reflected.
  - The whole update is combinational across all lanes and lands in the CRC register in the same cycle.
- Byte count: increases by popcount(tkeep) per accepted beat and clamps at 2^COUNT_WIDTH-1.
- States:
  - IDLE: CRC=INIT, count=0. An accepted beat with tlast=0 goes to ACTIVE; one with tlast=1 goes to DONE.
  - ACTIVE: an accepted beat with tlast=0 stays in ACTIVE; one with tlast=1 goes to DONE.
  - DONE: m_crc_valid=1 and the result and count are held stable. On m_crc_valid && m_crc_ready → IDLE.
- Result timing:
  - m_crc_valid rises on the cycle after the tlast beat is accepted (latency 1).
  - m_crc = transform(CRC including the tlast beat). Transform order is invert first, then byte bit-reverse.
  - The running CRC and count are reset to INIT/0 in that same cycle.
- Back-pressure: s_axis_tready = !m_crc_valid || m_crc_ready.
  - The next frame's first beat may be accepted in the same cycle the result is consumed (zero-bubble).
  - While a result is pending and m_crc_ready=0, input stalls.
- Boundary conditions:
  - A tlast beat with tkeep=0 closes the frame without folding any byte. An empty frame yields transform(INIT) with count 0.
  - A non-last beat with tkeep=0 is accepted and has no effect.
  - While s_axis_tvalid=0, nothing changes.
  - rst mid-frame or while DONE discards everything and returns to reset values on the next edge.
- Output stability: m_crc and m_crc_bytes must not change while m_crc_valid=1 and m_crc_ready=0.

Test Plan:
1. CRC_WIDTH=16, POLY=16'h1021, INIT=16'hFFFF, OUT_INVERT=0, OUT_BIT_REVERSE=0, DATA_WIDTH=32. Send ASCII "123456789" as beats "1234", "5678", "9" with final tkeep=4'b0001 → m_crc=16'h29B1, m_crc_bytes=9, valid 1 cycle after tlast.
2. CRC_WIDTH=32, POLY=32'h04C11DB7, INIT=all ones, DATA_WIDTH=64, same string in beats of 8+1 bytes:
   - OUT_INVERT=0 → 32'h0376E6E7.
   - OUT_INVERT=1 → 32'hFC891918.
3. Defaults, single beat tlast=1 with tkeep=0 → m_crc=16'h0000 (complemented INIT, then reversed), m_crc_bytes=0.
4. Non-contiguous tkeep: Test 1 configuration, send "12x3" with tkeep=4'b1011 (drops "x"), then "45678", then "9" → 16'h29B1, m_crc_bytes=9.
5. Back-pressure: hold m_crc_ready=0 for 10 cycles after frame 1 completes.
   - s_axis_tready stays 0, and m_crc and m_crc_bytes stay stable.
   - Raise m_crc_ready in the same cycle frame 2's first beat is presented → the beat is accepted that cycle.
   - Frame 2 result is correct and independent of frame 1.
6. Assert rst for 1 cycle in the middle of frame 1, then send the full Test 1 frame → 16'h29B1 with no corruption from the aborted frame.
